// File: rtl/sdu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sdu_pkg
// Description : Shared constants and state encoding for the transmit-side
//               SDU frame distributor.
// Revision    : 1.0 - initial release
// ============================================================================
package sdu_pkg;

  // Default word layout: [17]=sop, [16]=eop, [15:0]=payload
  localparam int SDU_DATA_WIDTH = 18;
  localparam int SOP_BIT        = SDU_DATA_WIDTH - 1;
  localparam int EOP_BIT        = SDU_DATA_WIDTH - 2;

  // Terminator appended to a frame that lost its eop: sop=0, eop=1, payload=0
  localparam logic [SDU_DATA_WIDTH-1:0] TERM_WORD = 18'h10000;

  // Distributor state encoding
  localparam int STATE_W = 2;
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 2'd0,
    ST_FWD   = 2'd1,
    ST_DROP  = 2'd2,
    ST_ABORT = 2'd3
  } sdu_state_e;

endpackage : sdu_pkg
`default_nettype wire

// File: rtl/sdu_sat_cnt.sv
`default_nettype none
// ============================================================================
// Module      : sdu_sat_cnt
// Description : Statistics counter that increments on request and sticks at
//               all-ones instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module sdu_sat_cnt #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] cnt
);

  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;

  // Next count: step by one unless already saturated
  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {CNT_WIDTH{1'b1}})) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  // Count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule : sdu_sat_cnt
`default_nettype wire

// File: rtl/tx_sdu1s2.sv
`default_nettype none
// ============================================================================
// Module      : tx_sdu1s2
// Description : Transmit-side 1-to-2 frame distributor. Steers whole frames
//               from one framed word stream into per-channel SDU FIFOs by a
//               destination field in the sop word, with sop-time admission,
//               length policing and missing-eop repair.
// Revision    : 1.0 - initial release
// ============================================================================
module tx_sdu1s2
  import sdu_pkg::*;
#(
  parameter int CHN_NUM       = 2,
  parameter int CHN_NUM_WIDTH = 1,
  parameter int DATA_WIDTH    = SDU_DATA_WIDTH,
  parameter int DEST_LSB      = 8,
  parameter int MAX_LEN       = 512,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                  clk_sys,
  input  logic                  rst_sys,
  input  logic                  chip_cs,
  input  logic                  src_sdu_dval,
  input  logic [DATA_WIDTH-1:0] src_sdu_data,
  output logic                  src_sdu_rdy,
  input  logic [CHN_NUM-1:0]    chn_sdu_afull,
  output logic [CHN_NUM-1:0]    sdu_chn_wren,
  output logic [DATA_WIDTH-1:0] sdu_chn_data,
  output logic [CNT_WIDTH-1:0]  frm_cnt,
  output logic [CNT_WIDTH-1:0]  drop_cnt
);

  localparam int SOP_IDX = DATA_WIDTH - 1;
  localparam int EOP_IDX = DATA_WIDTH - 2;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);
  localparam logic [LEN_W-1:0]      MAX_LEN_V = LEN_W'(MAX_LEN);
  localparam logic [DATA_WIDTH-1:0] TERM      = {2'b01, {(DATA_WIDTH-2){1'b0}}};

  sdu_state_e              state_q, state_d;
  logic [LEN_W-1:0]         len_q, len_d;
  logic [CHN_NUM_WIDTH-1:0] dest_q, dest_d;
  logic [DATA_WIDTH-1:0]    held_q, held_d;
  logic [CHN_NUM-1:0]       wren_q, wren_d;
  logic [DATA_WIDTH-1:0]    data_q, data_d;

  logic                     accept;
  logic                     in_sop;
  logic                     in_eop;
  logic [LEN_W-1:0]         len_inc;
  logic [DATA_WIDTH-1:0]    eval_word;
  logic [CHN_NUM_WIDTH-1:0] eval_dest;
  logic                     eval_ok;
  logic                     eval_eop;
  logic                     start_sop;
  logic                     frm_inc;
  logic                     drop_inc;

  function automatic logic [CHN_NUM-1:0] dest_onehot(input logic [CHN_NUM_WIDTH-1:0] d);
    logic [CHN_NUM-1:0] oh;
    oh = '0;
    for (int i = 0; i < CHN_NUM; i++) begin
      if (d == i[CHN_NUM_WIDTH-1:0]) oh[i] = 1'b1;
    end
    return oh;
  endfunction

  // Ready comes straight from the state register; the ABORT cycle is
  // reserved for writing the held sop, so no new word may enter then.
  assign src_sdu_rdy = chip_cs && (state_q != ST_ABORT) && !rst_sys;
  assign accept      = src_sdu_dval && src_sdu_rdy;
  assign in_sop      = src_sdu_data[SOP_IDX];
  assign in_eop      = src_sdu_data[EOP_IDX];
  assign len_inc     = len_q + LEN_W'(1);

  // Admission check for a frame start: the held word in ABORT, else the input
  always_comb begin
    eval_word = (state_q == ST_ABORT) ? held_q : src_sdu_data;
    eval_dest = eval_word[DEST_LSB +: CHN_NUM_WIDTH];
    eval_eop  = eval_word[EOP_IDX];
    eval_ok   = 1'b0;
    for (int i = 0; i < CHN_NUM; i++) begin
      if (eval_dest == i[CHN_NUM_WIDTH-1:0]) eval_ok = !chn_sdu_afull[i];
    end
  end

  // Next-state, write and counter-increment decisions
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    dest_d    = dest_q;
    held_d    = held_q;
    wren_d    = '0;
    data_d    = data_q;
    frm_inc   = 1'b0;
    drop_inc  = 1'b0;
    start_sop = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Non-sop words here are orphans and fall through unwritten
        if (accept && in_sop) start_sop = 1'b1;
      end

      ST_DROP: begin
        if (accept) begin
          if (in_sop) begin
            start_sop = 1'b1;
          end else if (in_eop) begin
            state_d = ST_IDLE;
          end
        end
      end

      ST_FWD: begin
        if (accept) begin
          if (in_sop) begin
            // Missing eop: close the old frame now, replay the sop next cycle
            held_d   = src_sdu_data;
            wren_d   = dest_onehot(dest_q);
            data_d   = TERM;
            drop_inc = 1'b1;
            state_d  = ST_ABORT;
          end else begin
            len_d  = len_inc;
            wren_d = dest_onehot(dest_q);
            data_d = src_sdu_data;
            if (in_eop) begin
              frm_inc = 1'b1;
              state_d = ST_IDLE;
            end else if (len_inc == MAX_LEN_V) begin
              // Overlong frame: cut it here and swallow the rest
              data_d[EOP_IDX] = 1'b1;
              drop_inc        = 1'b1;
              state_d         = ST_DROP;
            end
          end
        end
      end

      ST_ABORT: begin
        start_sop = 1'b1;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (start_sop) begin
      len_d  = LEN_W'(1);
      dest_d = eval_dest;
      if (eval_ok) begin
        wren_d = dest_onehot(eval_dest);
        data_d = eval_word;
        if (eval_eop) begin
          frm_inc = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_FWD;
        end
      end else begin
        drop_inc = 1'b1;
        state_d  = eval_eop ? ST_IDLE : ST_DROP;
      end
    end
  end

  // Control and output registers
  always_ff @(posedge clk_sys or posedge rst_sys) begin
    if (rst_sys) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      dest_q  <= '0;
      held_q  <= '0;
      wren_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      dest_q  <= dest_d;
      held_q  <= held_d;
      wren_q  <= wren_d;
      data_q  <= data_d;
    end
  end

  assign sdu_chn_wren = wren_q;
  assign sdu_chn_data = data_q;

  sdu_sat_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_frm_cnt (
    .clk (clk_sys),
    .rst (rst_sys),
    .inc (frm_inc),
    .cnt (frm_cnt)
  );

  sdu_sat_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_drop_cnt (
    .clk (clk_sys),
    .rst (rst_sys),
    .inc (drop_inc),
    .cnt (drop_cnt)
  );

endmodule : tx_sdu1s2
`default_nettype wire

// File: tb/tb_tx_sdu1s2.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_tx_sdu1s2
// Description : Self-checking bench for the SDU 1-to-2 frame distributor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tx_sdu1s2;

  logic        clk_sys = 1'b0;
  logic        rst_sys;
  logic        chip_cs;
  logic        src_sdu_dval;
  logic        dval4;
  logic [17:0] src_sdu_data;
  logic [1:0]  chn_sdu_afull;
  logic        src_sdu_rdy, rdy4;
  logic [1:0]  sdu_chn_wren, wren4;
  logic [17:0] sdu_chn_data, data4;
  logic [15:0] frm_cnt, drop_cnt, frm4, drop4;

  always #5 clk_sys = ~clk_sys;

  tx_sdu1s2 dut (
    .clk_sys       (clk_sys),
    .rst_sys       (rst_sys),
    .chip_cs       (chip_cs),
    .src_sdu_dval  (src_sdu_dval),
    .src_sdu_data  (src_sdu_data),
    .src_sdu_rdy   (src_sdu_rdy),
    .chn_sdu_afull (chn_sdu_afull),
    .sdu_chn_wren  (sdu_chn_wren),
    .sdu_chn_data  (sdu_chn_data),
    .frm_cnt       (frm_cnt),
    .drop_cnt      (drop_cnt)
  );

  // Short-frame instance for length policing
  tx_sdu1s2 #(.MAX_LEN(4)) dut4 (
    .clk_sys       (clk_sys),
    .rst_sys       (rst_sys),
    .chip_cs       (chip_cs),
    .src_sdu_dval  (dval4),
    .src_sdu_data  (src_sdu_data),
    .src_sdu_rdy   (rdy4),
    .chn_sdu_afull (chn_sdu_afull),
    .sdu_chn_wren  (wren4),
    .sdu_chn_data  (data4),
    .frm_cnt       (frm4),
    .drop_cnt      (drop4)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- frame-level reference model ----------------
  localparam int MAXL = 512;
  logic [17:0] q0[$];
  logic [17:0] q1[$];
  bit          m_in_frame;
  int          m_dest, m_len, m_frm, m_drp;
  bit          mon_en = 1'b0;

  task automatic push(input int ch, input logic [17:0] w);
    if (ch == 0) q0.push_back(w);
    else         q1.push_back(w);
  endtask

  // Apply the frame rules to one accepted word
  task automatic model_step(input logic [17:0] w, input logic [1:0] af);
    bit sop = w[17];
    bit eop = w[16];
    int d   = int'(w[8]);
    if (sop) begin
      if (m_in_frame) begin
        push(m_dest, 18'h10000);
        m_drp++;
      end
      m_in_frame = 1'b0;
      if (af[d]) begin
        m_drp++;
      end else begin
        push(d, w);
        if (eop) m_frm++;
        else begin
          m_in_frame = 1'b1;
          m_dest     = d;
          m_len      = 1;
        end
      end
    end else if (m_in_frame) begin
      m_len++;
      if (eop) begin
        push(m_dest, w);
        m_frm++;
        m_in_frame = 1'b0;
      end else if (m_len == MAXL) begin
        push(m_dest, w | 18'h10000);
        m_drp++;
        m_in_frame = 1'b0;
      end else begin
        push(m_dest, w);
      end
    end
  endtask

  // Random-phase monitor: check writes against model queues, then feed the model
  always @(negedge clk_sys) begin
    if (mon_en) begin
      if (sdu_chn_wren != 2'b00) begin
        chk("rnd_wren_onehot", 32'($countones(sdu_chn_wren)), 32'd1);
        if (sdu_chn_wren == 2'b01) begin
          if (q0.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL rnd_ch0_extra: got write 0x%0h required none", sdu_chn_data);
          end else chk("rnd_ch0_data", 32'(sdu_chn_data), 32'(q0.pop_front()));
        end else if (sdu_chn_wren == 2'b10) begin
          if (q1.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL rnd_ch1_extra: got write 0x%0h required none", sdu_chn_data);
          end else chk("rnd_ch1_data", 32'(sdu_chn_data), 32'(q1.pop_front()));
        end
      end
      if (src_sdu_dval && src_sdu_rdy) model_step(src_sdu_data, chn_sdu_afull);
    end
  end

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [1:0]  af;
    logic        dv;
    logic [17:0] d;
    logic        rdy;
    logic [1:0]  wren;
    logic [17:0] od;
    logic [15:0] frm;
    logic [15:0] drp;
  } vec_t;

  localparam int NVEC = 22;
  vec_t tbl[NVEC];

  logic [17:0] trunc_in[6];
  logic [17:0] got4[$];

  task automatic cyc_in(input logic cs, input logic dv, input logic [17:0] d);
    @(posedge clk_sys); #1;
    chip_cs = cs; src_sdu_dval = dv; src_sdu_data = d;
    @(negedge clk_sys);
  endtask

  task automatic do_reset();
    @(posedge clk_sys); #1;
    rst_sys = 1'b1; src_sdu_dval = 1'b0; dval4 = 1'b0; chip_cs = 1'b1;
    chn_sdu_afull = 2'b00;
    repeat (2) @(posedge clk_sys);
    #1 rst_sys = 1'b0;
  endtask

  initial begin
    // frame 1: dest0, 5 words
    tbl[0]  = '{2'b00, 1'b1, 18'h20011, 1'b1, 2'b00, 18'h00000, 16'd0, 16'd0};
    tbl[1]  = '{2'b00, 1'b1, 18'h00022, 1'b1, 2'b01, 18'h20011, 16'd0, 16'd0};
    tbl[2]  = '{2'b00, 1'b1, 18'h00033, 1'b1, 2'b01, 18'h00022, 16'd0, 16'd0};
    tbl[3]  = '{2'b00, 1'b1, 18'h00044, 1'b1, 2'b01, 18'h00033, 16'd0, 16'd0};
    tbl[4]  = '{2'b00, 1'b1, 18'h10055, 1'b1, 2'b01, 18'h00044, 16'd0, 16'd0};
    tbl[5]  = '{2'b00, 1'b0, 18'h00000, 1'b1, 2'b01, 18'h10055, 16'd1, 16'd0};
    // frame to ch1 while ch1 almost full: dropped whole
    tbl[6]  = '{2'b10, 1'b1, 18'h20177, 1'b1, 2'b00, 18'h00000, 16'd1, 16'd0};
    tbl[7]  = '{2'b10, 1'b1, 18'h00088, 1'b1, 2'b00, 18'h00000, 16'd1, 16'd1};
    tbl[8]  = '{2'b10, 1'b1, 18'h10099, 1'b1, 2'b00, 18'h00000, 16'd1, 16'd1};
    // afull released: next ch1 frame passes
    tbl[9]  = '{2'b00, 1'b1, 18'h20155, 1'b1, 2'b00, 18'h00000, 16'd1, 16'd1};
    tbl[10] = '{2'b00, 1'b1, 18'h10066, 1'b1, 2'b10, 18'h20155, 16'd1, 16'd1};
    tbl[11] = '{2'b00, 1'b0, 18'h00000, 1'b1, 2'b10, 18'h10066, 16'd2, 16'd1};
    // single-word frame to ch1
    tbl[12] = '{2'b00, 1'b1, 18'h30112, 1'b1, 2'b00, 18'h00000, 16'd2, 16'd1};
    tbl[13] = '{2'b00, 1'b0, 18'h00000, 1'b1, 2'b10, 18'h30112, 16'd3, 16'd1};
    // ch0 frame interrupted by a ch1 sop: terminator, then new frame
    tbl[14] = '{2'b00, 1'b1, 18'h20021, 1'b1, 2'b00, 18'h00000, 16'd3, 16'd1};
    tbl[15] = '{2'b00, 1'b1, 18'h00031, 1'b1, 2'b01, 18'h20021, 16'd3, 16'd1};
    tbl[16] = '{2'b00, 1'b1, 18'h20141, 1'b1, 2'b01, 18'h00031, 16'd3, 16'd1};
    tbl[17] = '{2'b00, 1'b1, 18'h00051, 1'b0, 2'b01, 18'h10000, 16'd3, 16'd2};
    tbl[18] = '{2'b00, 1'b1, 18'h00051, 1'b1, 2'b10, 18'h20141, 16'd3, 16'd2};
    tbl[19] = '{2'b00, 1'b1, 18'h10061, 1'b1, 2'b10, 18'h00051, 16'd3, 16'd2};
    tbl[20] = '{2'b00, 1'b0, 18'h00000, 1'b1, 2'b10, 18'h10061, 16'd4, 16'd2};
    tbl[21] = '{2'b00, 1'b0, 18'h00000, 1'b1, 2'b00, 18'h00000, 16'd4, 16'd2};

    trunc_in[0] = 18'h20001; trunc_in[1] = 18'h00002; trunc_in[2] = 18'h00003;
    trunc_in[3] = 18'h00004; trunc_in[4] = 18'h00005; trunc_in[5] = 18'h10006;

    rst_sys = 1'b1; chip_cs = 1'b1; src_sdu_dval = 1'b0; dval4 = 1'b0;
    src_sdu_data = '0; chn_sdu_afull = 2'b00;

    // Reset state
    repeat (2) @(negedge clk_sys);
    chk("rst_wren", 32'(sdu_chn_wren), 32'd0);
    chk("rst_data", 32'(sdu_chn_data), 32'd0);
    chk("rst_frm",  32'(frm_cnt), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    chk("rst_rdy",  32'(src_sdu_rdy), 32'd0);
    @(posedge clk_sys); #1 rst_sys = 1'b0;

    // Table-driven directed frames
    for (int k = 0; k < NVEC; k++) begin
      @(posedge clk_sys); #1;
      chn_sdu_afull = tbl[k].af; src_sdu_dval = tbl[k].dv; src_sdu_data = tbl[k].d;
      @(negedge clk_sys);
      chk($sformatf("tbl%0d_rdy", k),  32'(src_sdu_rdy),  32'(tbl[k].rdy));
      chk($sformatf("tbl%0d_wren", k), 32'(sdu_chn_wren), 32'(tbl[k].wren));
      if (tbl[k].wren != 2'b00)
        chk($sformatf("tbl%0d_data", k), 32'(sdu_chn_data), 32'(tbl[k].od));
      chk($sformatf("tbl%0d_frm", k),  32'(frm_cnt),  32'(tbl[k].frm));
      chk($sformatf("tbl%0d_drop", k), 32'(drop_cnt), 32'(tbl[k].drp));
    end

    // Length policing on the MAX_LEN=4 instance: 6-word frame
    for (int k = 0; k < 9; k++) begin
      @(posedge clk_sys); #1;
      dval4        = (k < 6);
      src_sdu_data = (k < 6) ? trunc_in[k] : 18'h0;
      @(negedge clk_sys);
      if (wren4 != 2'b00) begin
        chk("trunc_wren", 32'(wren4), 32'd1);
        got4.push_back(data4);
      end
    end
    chk("trunc_nwrites", 32'(got4.size()), 32'd4);
    for (int k = 0; k < 4; k++) begin
      if (k < got4.size())
        chk($sformatf("trunc_w%0d", k), 32'(got4[k]),
            32'((k == 3) ? (trunc_in[k] | 18'h10000) : trunc_in[k]));
    end
    chk("trunc_drop", 32'(drop4), 32'd1);
    chk("trunc_frm",  32'(frm4),  32'd0);

    // chip_cs stall mid-frame, then asynchronous reset mid-frame
    cyc_in(1'b1, 1'b1, 18'h20007);
    chk("stall_rdy_a", 32'(src_sdu_rdy), 32'd1);
    for (int k = 0; k < 3; k++) begin
      cyc_in(1'b0, 1'b1, 18'h00008);
      chk($sformatf("stall%0d_rdy", k), 32'(src_sdu_rdy), 32'd0);
      chk($sformatf("stall%0d_wren", k), 32'(sdu_chn_wren), (k == 0) ? 32'd1 : 32'd0);
    end
    cyc_in(1'b1, 1'b1, 18'h00008);
    chk("resume_wren0", 32'(sdu_chn_wren), 32'd0);
    cyc_in(1'b1, 1'b0, 18'h00000);
    chk("resume_wren", 32'(sdu_chn_wren), 32'd1);
    chk("resume_data", 32'(sdu_chn_data), 32'h00008);
    chk("pre_rst_frm", 32'(frm_cnt), 32'd4);
    @(posedge clk_sys); #1 rst_sys = 1'b1;
    #2;
    chk("mid_rst_wren", 32'(sdu_chn_wren), 32'd0);
    chk("mid_rst_data", 32'(sdu_chn_data), 32'd0);
    chk("mid_rst_frm",  32'(frm_cnt), 32'd0);
    chk("mid_rst_drop", 32'(drop_cnt), 32'd0);
    chk("mid_rst_rdy",  32'(src_sdu_rdy), 32'd0);
    @(posedge clk_sys); #1 rst_sys = 1'b0;
    // Orphan eop after reset is discarded, then a single-word frame passes
    cyc_in(1'b1, 1'b1, 18'h10009);
    cyc_in(1'b1, 1'b1, 18'h30003);
    chk("orphan_wren", 32'(sdu_chn_wren), 32'd0);
    cyc_in(1'b1, 1'b0, 18'h00000);
    chk("post_rst_wren", 32'(sdu_chn_wren), 32'd1);
    chk("post_rst_data", 32'(sdu_chn_data), 32'h30003);
    chk("post_rst_frm",  32'(frm_cnt), 32'd1);

    // Randomized traffic against the frame-level model
    do_reset();
    m_in_frame = 1'b0; m_dest = 0; m_len = 0; m_frm = 0; m_drp = 0;
    q0.delete(); q1.delete();
    mon_en = 1'b1;
    for (int seg = 0; seg < 12; seg++) begin
      @(posedge clk_sys); #1;
      chn_sdu_afull = 2'($urandom_range(0, 3));
      src_sdu_dval  = 1'b0;
      for (int c = 0; c < 40; c++) begin
        logic [17:0] w;
        @(posedge clk_sys); #1;
        w       = {2'b00, 16'($urandom)};
        w[17]   = ($urandom_range(0, 9) < 2);
        w[16]   = ($urandom_range(0, 3) == 0);
        chip_cs = ($urandom_range(0, 9) != 0);
        src_sdu_dval = ($urandom_range(0, 9) < 7);
        src_sdu_data = w;
      end
      @(posedge clk_sys); #1;
      src_sdu_dval = 1'b0; chip_cs = 1'b1;
      repeat (3) @(posedge clk_sys);
    end
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    mon_en = 1'b0;
    chk("rnd_frm_cnt",  32'(frm_cnt),  32'(m_frm));
    chk("rnd_drop_cnt", 32'(drop_cnt), 32'(m_drp));
    chk("rnd_q0_empty", 32'(q0.size()), 32'd0);
    chk("rnd_q1_empty", 32'(q1.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_tx_sdu1s2
`default_nettype wire
